// File: rtl/weight_stream_feeder.sv
// Fetches kernel slices from sequential weight memory and writes them into the layer engine's weight RAM.
// Optional `WEIGHT_FEEDER_PREFETCH_EN` adds a slice buffer refilled after each done.
//   state    | meaning
//   IDLE     | no update yet since reset
//   REQ      | issue one memory read at the read pointer
//   WAIT     | wait for the read return
//   WRITE    | strobe one slice into the engine
//   DONE     | update complete, done held
//   PREFETCH | refill the slice buffer (prefetch build only)
module weight_stream_feeder #(
  parameter int DATA_WIDTH              = 16,
  parameter int KERNEL_SIZE_MAX         = 3,
  parameter int PARA_KERNEL             = 2,
  parameter int WEIGHT_WRITE_ADDR_WIDTH = 10,
  parameter int SLICES_PER_UPDATE       = 2,
  parameter int MEM_ADDR_WIDTH          = 12,
  parameter int MEM_DEPTH               = 4096,
  localparam int WD = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * PARA_KERNEL * DATA_WIDTH,
  localparam int WA = WEIGHT_WRITE_ADDR_WIDTH * PARA_KERNEL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      update_weight_ram,
  input  logic [WA-1:0]             update_weight_ram_addr,
  input  logic                      stream_restart,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WD-1:0]             mem_rd_data,
  input  logic                      mem_rd_valid,
  output logic [WD-1:0]             weight_data,
  output logic [WA-1:0]             write_weight_data_addr,
  output logic                      weight_wr_en,
  output logic                      weight_data_done,
  output logic                      busy,
  output logic [7:0]                update_count
);

  localparam int SW = (SLICES_PER_UPDATE > 1) ? $clog2(SLICES_PER_UPDATE) : 1;
  localparam logic [SW-1:0] SLICE_LAST = SW'(SLICES_PER_UPDATE - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] PTR_LAST = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE
`ifdef WEIGHT_FEEDER_PREFETCH_EN
    , S_PREFETCH
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_next;
  logic [SW-1:0]             slice_q, slice_d;
  logic [WA-1:0]             lat_q, lat_d;
  logic [WD-1:0]             wdata_q, wdata_d;
  logic [WA-1:0]             waddr_q, waddr_d;
  logic                      done_q, done_d;
  logic [7:0]                count_q, count_d;
  logic                      arm_q, arm_d;
  logic                      rd_en;
`ifdef WEIGHT_FEEDER_PREFETCH_EN
  logic [WD-1:0]             buf_q [SLICES_PER_UPDATE];
  logic [WD-1:0]             buf_d [SLICES_PER_UPDATE];
  logic                      buf_full_q, buf_full_d;
  logic [SW-1:0]             pf_cnt_q, pf_cnt_d;
  logic                      pf_pend_q, pf_pend_d;
  logic                      from_buf_q, from_buf_d;
`endif

  // Lanes are added independently so a wrapping lane never carries into its neighbour.
  function automatic logic [WA-1:0] lane_add(input logic [WA-1:0] base, input logic [SW-1:0] s);
    logic [WA-1:0] res;
    res = '0;
    for (int i = 0; i < PARA_KERNEL; i++) begin
      res[i*WEIGHT_WRITE_ADDR_WIDTH +: WEIGHT_WRITE_ADDR_WIDTH] =
        base[i*WEIGHT_WRITE_ADDR_WIDTH +: WEIGHT_WRITE_ADDR_WIDTH] + WEIGHT_WRITE_ADDR_WIDTH'(s);
    end
    return res;
  endfunction

  assign ptr_next = (ptr_q == PTR_LAST) ? '0 : ptr_q + MEM_ADDR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    slice_d = slice_q;
    lat_d   = lat_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    done_d  = done_q;
    count_d = count_q;
    arm_d   = arm_q | ~update_weight_ram;
    rd_en   = 1'b0;
`ifdef WEIGHT_FEEDER_PREFETCH_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    pf_cnt_d   = pf_cnt_q;
    pf_pend_d  = pf_pend_q;
    from_buf_d = from_buf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (stream_restart) begin
          ptr_d = '0;
`ifdef WEIGHT_FEEDER_PREFETCH_EN
          buf_full_d = 1'b0;
`endif
        end
        // arm_q makes acceptance edge-qualified after a completed update
        if (update_weight_ram && arm_q) begin
          lat_d   = update_weight_ram_addr;
          slice_d = '0;
          done_d  = 1'b0;
          arm_d   = 1'b0;
          state_d = S_REQ;
`ifdef WEIGHT_FEEDER_PREFETCH_EN
          from_buf_d = 1'b0;
          if (buf_full_q && !stream_restart) begin
            state_d    = S_WRITE;
            from_buf_d = 1'b1;
            buf_full_d = 1'b0;
            wdata_d    = buf_q[0];
            waddr_d    = lane_add(update_weight_ram_addr, '0);
          end
        end else if (state_q == S_DONE && !buf_full_q) begin
          state_d   = S_PREFETCH;
          pf_cnt_d  = '0;
          pf_pend_d = 1'b0;
`endif
        end
      end
      S_REQ: begin
        rd_en   = 1'b1;
        ptr_d   = ptr_next;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          wdata_d = mem_rd_data;
          waddr_d = lane_add(lat_q, slice_q);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (slice_q < SLICE_LAST) begin
          slice_d = slice_q + SW'(1);
          state_d = S_REQ;
`ifdef WEIGHT_FEEDER_PREFETCH_EN
          if (from_buf_q) begin
            state_d = S_WRITE;
            wdata_d = buf_q[slice_q + SW'(1)];
            waddr_d = lane_add(lat_q, slice_q + SW'(1));
          end
`endif
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
        end
      end
`ifdef WEIGHT_FEEDER_PREFETCH_EN
      S_PREFETCH: begin
        if (!pf_pend_q) begin
          rd_en     = 1'b1;
          ptr_d     = ptr_next;
          pf_pend_d = 1'b1;
        end else if (mem_rd_valid) begin
          buf_d[pf_cnt_q] = mem_rd_data;
          pf_pend_d       = 1'b0;
          if (pf_cnt_q == SLICE_LAST) begin
            buf_full_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            pf_cnt_d = pf_cnt_q + SW'(1);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      slice_q <= '0;
      lat_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
      arm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      slice_q <= slice_d;
      lat_q   <= lat_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      done_q  <= done_d;
      count_q <= count_d;
      arm_q   <= arm_d;
    end
  end

`ifdef WEIGHT_FEEDER_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLICES_PER_UPDATE; i++) buf_q[i] <= '0;
      buf_full_q <= 1'b0;
      pf_cnt_q   <= '0;
      pf_pend_q  <= 1'b0;
      from_buf_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      pf_cnt_q   <= pf_cnt_d;
      pf_pend_q  <= pf_pend_d;
      from_buf_q <= from_buf_d;
    end
  end
`endif

  assign mem_rd_en              = rd_en;
  assign mem_rd_addr            = ptr_q;
  assign weight_data            = wdata_q;
  assign write_weight_data_addr = waddr_q;
  assign weight_wr_en           = (state_q == S_WRITE);
  assign weight_data_done       = done_q;
  assign busy                   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign update_count           = count_q;

endmodule

// File: tb/tb_weight_stream_feeder.sv
// Directed bench for weight_stream_feeder (default build) with a small-depth memory model.
module tb_weight_stream_feeder;
  localparam int DW  = 16;
  localparam int KS  = 3;
  localparam int PK  = 2;
  localparam int WAW = 10;
  localparam int SPU = 2;
  localparam int MAW = 12;
  localparam int MD  = 4;
  localparam int WD  = KS * KS * PK * DW;
  localparam int WA  = WAW * PK;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           update_weight_ram = 1'b0;
  logic [WA-1:0]  update_weight_ram_addr = '0;
  logic           stream_restart = 1'b0;
  logic           mem_rd_en;
  logic [MAW-1:0] mem_rd_addr;
  logic [WD-1:0]  mem_rd_data;
  logic           mem_rd_valid;
  logic [WD-1:0]  weight_data;
  logic [WA-1:0]  write_weight_data_addr;
  logic           weight_wr_en;
  logic           weight_data_done;
  logic           busy;
  logic [7:0]     update_count;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            lat = 1;
  bit            auto_mem = 1'b1;
  logic          auto_v = 1'b0;
  logic          man_v = 1'b0;
  logic [WD-1:0] auto_d = '0;

  assign mem_rd_valid = auto_v | man_v;
  assign mem_rd_data  = auto_d;

  weight_stream_feeder #(
    .DATA_WIDTH(DW), .KERNEL_SIZE_MAX(KS), .PARA_KERNEL(PK),
    .WEIGHT_WRITE_ADDR_WIDTH(WAW), .SLICES_PER_UPDATE(SPU),
    .MEM_ADDR_WIDTH(MAW), .MEM_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst),
    .update_weight_ram(update_weight_ram),
    .update_weight_ram_addr(update_weight_ram_addr),
    .stream_restart(stream_restart),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .weight_data(weight_data), .write_weight_data_addr(write_weight_data_addr),
    .weight_wr_en(weight_wr_en), .weight_data_done(weight_data_done),
    .busy(busy), .update_count(update_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WD-1:0] word(input int a);
    logic [15:0] e;
    e = 16'hA000 + 16'(a) * 16'h0111;
    return {(KS*KS*PK){e}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 write strobe, 1 read strobe, 2 done; returns -1 if the bound expires
  task automatic wait_for(input int sel, output int when);
    when = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((sel == 0 && weight_wr_en === 1'b1) || (sel == 1 && mem_rd_en === 1'b1) ||
          (sel == 2 && weight_data_done === 1'b1)) begin
        when = cyc;
        break;
      end
    end
  endtask

  // Memory model: read seen in cycle C returns in cycle C+lat for one cycle.
  initial begin
    int a;
    forever begin
      @(negedge clk);
      if (auto_mem && mem_rd_en === 1'b1 && rst === 1'b0) begin
        a = int'(mem_rd_addr);
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 auto_v = 1'b1;
        auto_d = word(a);
        @(posedge clk);
        #1 auto_v = 1'b0;
      end
    end
  end

  initial begin
    int c, w, extra;
    @(negedge clk);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chkw("rst_wdata", weight_data, '0);
    chk("rst_waddr", 32'(write_weight_data_addr), 32'd0);
    chk("rst_wr_en", 32'(weight_wr_en), 32'd0);
    chk("rst_done", 32'(weight_data_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(update_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // L=1, lanes {9,9}
    lat = 1; update_weight_ram_addr = {10'd9, 10'd9}; update_weight_ram = 1'b1; c = cyc;
    wait_for(1, w); chk("t1_rd0_cyc", 32'(w), 32'(c + 1)); chk("t1_rd0_addr", 32'(mem_rd_addr), 32'd0);
    wait_for(0, w); chk("t1_wr0_cyc", 32'(w), 32'(c + 3));
    chkw("t1_wr0_data", weight_data, word(0));
    chk("t1_wr0_addr", 32'(write_weight_data_addr), 32'({10'd9, 10'd9}));
    wait_for(1, w); chk("t1_rd1_cyc", 32'(w), 32'(c + 4)); chk("t1_rd1_addr", 32'(mem_rd_addr), 32'd1);
    wait_for(0, w); chk("t1_wr1_cyc", 32'(w), 32'(c + 6));
    chkw("t1_wr1_data", weight_data, word(1));
    chk("t1_wr1_addr", 32'(write_weight_data_addr), 32'({10'd10, 10'd10}));
    chk("t1_busy_at_wr", 32'(busy), 32'd1);
    chk("t1_done_at_wr", 32'(weight_data_done), 32'd0);
    wait_for(2, w); chk("t1_done_cyc", 32'(w), 32'(c + 7));
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_count", 32'(update_count), 32'd1);
    chk("t1_wr_en_off", 32'(weight_wr_en), 32'd0);
    chkw("t1_data_hold", weight_data, word(1));
    chk("t1_addr_hold", 32'(write_weight_data_addr), 32'({10'd10, 10'd10}));
    update_weight_ram = 1'b0;
    @(negedge clk);

    // L=3, request held high past done
    lat = 3; update_weight_ram_addr = {10'd100, 10'd200}; update_weight_ram = 1'b1; c = cyc;
    wait_for(1, w); chk("t2_rd0_cyc", 32'(w), 32'(c + 1)); chk("t2_rd0_addr", 32'(mem_rd_addr), 32'd2);
    wait_for(0, w); chk("t2_wr0_cyc", 32'(w), 32'(c + 5)); chkw("t2_wr0_data", weight_data, word(2));
    chk("t2_wr0_addr", 32'(write_weight_data_addr), 32'({10'd100, 10'd200}));
    wait_for(1, w); chk("t2_rd1_cyc", 32'(w), 32'(c + 6)); chk("t2_rd1_addr", 32'(mem_rd_addr), 32'd3);
    wait_for(0, w); chk("t2_wr1_cyc", 32'(w), 32'(c + 10)); chkw("t2_wr1_data", weight_data, word(3));
    chk("t2_wr1_addr", 32'(write_weight_data_addr), 32'({10'd101, 10'd201}));
    wait_for(2, w); chk("t2_done_cyc", 32'(w), 32'(c + 11));
    chk("t2_count", 32'(update_count), 32'd2);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      extra += int'(mem_rd_en) + int'(busy) + int'(weight_wr_en) + int'(!weight_data_done);
    end
    chk("t2_no_reaccept", 32'(extra), 32'd0);
    chk("t2_count_hold", 32'(update_count), 32'd2);
    update_weight_ram = 1'b0;
    @(negedge clk);

    // pointer wraps at depth 4, lane 0 wraps without carrying into lane 1
    lat = 1; update_weight_ram_addr = {10'h005, 10'h3FF}; update_weight_ram = 1'b1; c = cyc;
    wait_for(1, w); chk("t3_rd0_cyc", 32'(w), 32'(c + 1)); chk("t3_rd0_addr", 32'(mem_rd_addr), 32'd0);
    wait_for(0, w); chkw("t3_wr0_data", weight_data, word(0));
    chk("t3_wr0_addr", 32'(write_weight_data_addr), 32'({10'h005, 10'h3FF}));
    wait_for(1, w); chk("t3_rd1_addr", 32'(mem_rd_addr), 32'd1);
    wait_for(0, w); chk("t3_wr1_cyc", 32'(w), 32'(c + 6)); chkw("t3_wr1_data", weight_data, word(1));
    chk("t3_wr1_addr", 32'(write_weight_data_addr), 32'({10'h006, 10'h000}));
    wait_for(2, w); chk("t3_done_cyc", 32'(w), 32'(c + 7));
    chk("t3_count", 32'(update_count), 32'd3);
    update_weight_ram = 1'b0;
    @(negedge clk);

    // reset while waiting for a read, then a late return
    auto_mem = 1'b0; update_weight_ram_addr = {10'd1, 10'd2}; update_weight_ram = 1'b1; c = cyc;
    wait_for(1, w); chk("t4_rd_cyc", 32'(w), 32'(c + 1)); chk("t4_rd_addr", 32'(mem_rd_addr), 32'd2);
    @(negedge clk);
    chk("t4_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1; update_weight_ram = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_count", 32'(update_count), 32'd0);
    chk("t4_rst_done", 32'(weight_data_done), 32'd0);
    chkw("t4_rst_wdata", weight_data, '0);
    chk("t4_rst_waddr", 32'(write_weight_data_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0; man_v = 1'b1; auto_d = word(7);
    @(negedge clk);
    man_v = 1'b0;
    extra = int'(weight_wr_en);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      extra += int'(weight_wr_en) + int'(busy);
    end
    chk("t4_late_valid_ignored", 32'(extra), 32'd0);
    auto_mem = 1'b1; lat = 2; update_weight_ram = 1'b1; c = cyc;
    wait_for(1, w); chk("t4_rd0_cyc", 32'(w), 32'(c + 1)); chk("t4_rd0_addr", 32'(mem_rd_addr), 32'd0);
    wait_for(0, w); chk("t4_wr0_cyc", 32'(w), 32'(c + 4)); chkw("t4_wr0_data", weight_data, word(0));
    wait_for(2, w); chk("t4_done_cyc", 32'(w), 32'(c + 9));
    chk("t4_count", 32'(update_count), 32'd1);
    update_weight_ram = 1'b0;
    @(negedge clk);

    // restart with request in the same cycle, then restart while busy is ignored
    lat = 1; stream_restart = 1'b1; update_weight_ram = 1'b1; update_weight_ram_addr = {10'd50, 10'd60}; c = cyc;
    @(negedge clk);
    chk("t5_rd_en", 32'(mem_rd_en), 32'd1);
    chk("t5_rd0_addr", 32'(mem_rd_addr), 32'd0);
    wait_for(1, w); chk("t5_rd1_cyc", 32'(w), 32'(c + 4)); chk("t5_rd1_addr", 32'(mem_rd_addr), 32'd1);
    stream_restart = 1'b0;
    wait_for(0, w); chk("t5_wr1_addr", 32'(write_weight_data_addr), 32'({10'd51, 10'd61}));
    wait_for(2, w); chk("t5_done_cyc", 32'(w), 32'(c + 7));
    chk("t5_count", 32'(update_count), 32'd2);
    update_weight_ram = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
